// File: rtl/difftest_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : difftest_pkg
//  Description : Shared types for the difftest commit path: the commit-entry
//                record, the FIFO slot record (entry + trap tag), the trap
//                opcode constant and the monitor state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package difftest_pkg;

    // Storage width of PC/data fields; the monitor's XLEN must not exceed it.
    localparam int         c_XLEN_MAX    = 64;
    localparam logic [6:0] c_TRAP_OPCODE = 7'h6b;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    typedef struct packed {
        logic [c_XLEN_MAX-1:0] pc;
        logic [31:0]           inst;
        logic                  wen;
        logic [4:0]            wdest;
        logic [c_XLEN_MAX-1:0] wdata;
    } commit_entry_t;

    // A queued commit plus the trap tag and the trap code captured with it.
    typedef struct packed {
        commit_entry_t c;
        logic          trap;
        logic [7:0]    code;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/commit_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : commit_fifo
//  Description : Circular buffer accepting up to NCH entries per cycle
//                (already compacted into slots 0..wr_cnt_i-1) and releasing
//                one entry per cycle from the head.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                wr_cnt_i        - number of slots of wr_data_i to append
//                wr_data_i       - compacted entries, slot 0 is oldest
//                rd_en_i         - drop the head entry this edge
//                rd_data_o       - current head entry
//                count_o         - number of entries held
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_fifo
    import difftest_pkg::*;
#(
    parameter  int NCH   = 2,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int WCW   = $clog2(NCH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [WCW-1:0]            wr_cnt_i,
    input  fifo_entry_t [NCH-1:0]     wr_data_i,
    input  logic                      rd_en_i,
    output fifo_entry_t               rd_data_o,
    output logic [CW-1:0]             count_o
);

    fifo_entry_t     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Storage carries no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (WCW'(k) < wr_cnt_i) begin
                mem_q[wr_ptr_q + PW'(k)] <= wr_data_i[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide, so the sums wrap modulo DEPTH.
            wr_ptr_q <= wr_ptr_q + PW'(wr_cnt_i);
            if (rd_en_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(wr_cnt_i) - CW'(rd_en_i);
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule
`default_nettype wire

// File: rtl/commit_stream_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : commit_stream_monitor
//  Description : Collects up to NCH retire events per cycle, queues them in
//                order and replays them one per cycle on a single commit
//                port. Tracks cycle/instruction counters, input overflow and
//                the good/bad trap instruction.
//  Ports       : clk, rst_n             - clock, asynchronous active-low reset
//                in_valid/pc/inst/wen/wdest/wdata - per-lane commit inputs
//                in_a0                  - x10 value, source of the trap code
//                in_ready               - all lanes may be presented
//                out_valid/pc/inst/wen/wdest/wdata - single commit port
//                trap_valid/code/pc     - sticky trap report
//                cycle_cnt, instr_cnt   - activity counters
//                overflow               - sticky dropped-input flag
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_stream_monitor
    import difftest_pkg::*;
#(
    parameter int         NCH         = 2,
    parameter int         DEPTH       = 8,
    parameter int         XLEN        = 64,
    parameter logic [6:0] TRAP_OPCODE = c_TRAP_OPCODE
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      in_valid,
    input  logic [NCH*XLEN-1:0] in_pc,
    input  logic [NCH*32-1:0]   in_inst,
    input  logic [NCH-1:0]      in_wen,
    input  logic [NCH*5-1:0]    in_wdest,
    input  logic [NCH*XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0]     in_a0,
    output logic                in_ready,
    output logic                out_valid,
    output logic [XLEN-1:0]     out_pc,
    output logic [31:0]         out_inst,
    output logic                out_wen,
    output logic [7:0]          out_wdest,
    output logic [XLEN-1:0]     out_wdata,
    output logic                trap_valid,
    output logic [7:0]          trap_code,
    output logic [XLEN-1:0]     trap_pc,
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         instr_cnt,
    output logic                overflow
);

    localparam int              CW          = $clog2(DEPTH + 1);
    localparam int              WCW         = $clog2(NCH + 1);
    localparam logic [CW-1:0]   c_READY_MAX = CW'(DEPTH - NCH);

    state_e                 state_q;
    logic                   out_valid_q;
    logic [XLEN-1:0]        out_pc_q;
    logic [31:0]            out_inst_q;
    logic                   out_wen_q;
    logic [7:0]             out_wdest_q;
    logic [XLEN-1:0]        out_wdata_q;
    logic                   trap_valid_q;
    logic [7:0]             trap_code_q;
    logic [XLEN-1:0]        trap_pc_q;
    logic [63:0]            cycle_cnt_q;
    logic [63:0]            instr_cnt_q;
    logic                   overflow_q;

    fifo_entry_t [NCH-1:0]  w_lane;
    fifo_entry_t [NCH-1:0]  w_wr_data;
    logic [WCW-1:0]         w_slot;
    logic [WCW-1:0]         w_wr_cnt;
    logic                   w_trap_seen;
    logic                   w_ready;
    logic                   w_pop;
    logic [CW-1:0]          w_count;
    fifo_entry_t            w_head;
    logic                   w_unused_a0;

    // Only the low byte of a0 forms the trap code.
    assign w_unused_a0 = &{1'b0, in_a0[XLEN-1:8]};

    // Unpack the flat lane buses into entry records.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            w_lane[k].c.pc    = c_XLEN_MAX'(in_pc[k*XLEN +: XLEN]);
            w_lane[k].c.inst  = in_inst[k*32 +: 32];
            w_lane[k].c.wen   = in_wen[k];
            w_lane[k].c.wdest = in_wdest[k*5 +: 5];
            w_lane[k].c.wdata = c_XLEN_MAX'(in_wdata[k*XLEN +: XLEN]);
            w_lane[k].trap    = (in_inst[k*32 +: 7] == TRAP_OPCODE);
            w_lane[k].code    = in_a0[7:0];
        end
    end

    // Lane compaction: each valid lane takes the next free slot, so invalid
    // lanes leave no hole. Everything younger than a trap lane is dropped.
    always_comb begin
        w_wr_data   = '0;
        w_slot      = '0;
        w_trap_seen = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (in_valid[k] && !w_trap_seen) begin
                for (int j = 0; j < NCH; j++) begin
                    if (w_slot == WCW'(j)) begin
                        w_wr_data[j] = w_lane[k];
                    end
                end
                w_slot = w_slot + WCW'(1);
                if (w_lane[k].trap) begin
                    w_trap_seen = 1'b1;
                end
            end
        end
    end

    // Ready looks only at registered state so it never depends on in_valid
    // or on the pop taking place in the same cycle.
    assign w_ready  = (state_q == ST_RUN) && (w_count <= c_READY_MAX);
    assign w_wr_cnt = w_ready ? w_slot : '0;
    assign w_pop    = (state_q != ST_HALT) && (w_count != '0);

    commit_fifo #(
        .NCH   (NCH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_cnt_i  (w_wr_cnt),
        .wr_data_i (w_wr_data),
        .rd_en_i   (w_pop),
        .rd_data_o (w_head),
        .count_o   (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= '0;
            out_wen_q    <= 1'b0;
            out_wdest_q  <= '0;
            out_wdata_q  <= '0;
            trap_valid_q <= 1'b0;
            trap_code_q  <= '0;
            trap_pc_q    <= '0;
            cycle_cnt_q  <= '0;
            instr_cnt_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (state_q != ST_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
            end

            // Payload fields hold their last value when nothing is popped.
            out_valid_q <= w_pop;
            if (w_pop) begin
                out_pc_q    <= w_head.c.pc[XLEN-1:0];
                out_inst_q  <= w_head.c.inst;
                out_wen_q   <= w_head.c.wen;
                out_wdest_q <= {3'b000, w_head.c.wdest};
                out_wdata_q <= w_head.c.wdata[XLEN-1:0];
                instr_cnt_q <= instr_cnt_q + 64'd1;
                if (w_head.trap) begin
                    trap_valid_q <= 1'b1;
                    trap_pc_q    <= w_head.c.pc[XLEN-1:0];
                    trap_code_q  <= w_head.code;
                    state_q      <= ST_HALT;
                end
            end

            // A trap can only be accepted in RUN, and a trap can only be
            // popped in DRAIN, so these two state updates never collide.
            if (w_ready && w_trap_seen) begin
                state_q <= ST_DRAIN;
            end

            if ((state_q == ST_RUN) && !w_ready && (|in_valid)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_inst   = out_inst_q;
    assign out_wen    = out_wen_q;
    assign out_wdest  = out_wdest_q;
    assign out_wdata  = out_wdata_q;
    assign trap_valid = trap_valid_q;
    assign trap_code  = trap_code_q;
    assign trap_pc    = trap_pc_q;
    assign cycle_cnt  = cycle_cnt_q;
    assign instr_cnt  = instr_cnt_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_commit_stream_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_stream_monitor
//  Description : Scoreboard bench for commit_stream_monitor with a queue
//                based reference model of the commit stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_stream_monitor;

    localparam int NCH   = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCH-1:0]      in_valid;
    logic [NCH*XLEN-1:0] in_pc;
    logic [NCH*32-1:0]   in_inst;
    logic [NCH-1:0]      in_wen;
    logic [NCH*5-1:0]    in_wdest;
    logic [NCH*XLEN-1:0] in_wdata;
    logic [XLEN-1:0]     in_a0;
    logic                in_ready;
    logic                out_valid;
    logic [XLEN-1:0]     out_pc;
    logic [31:0]         out_inst;
    logic                out_wen;
    logic [7:0]          out_wdest;
    logic [XLEN-1:0]     out_wdata;
    logic                trap_valid;
    logic [7:0]          trap_code;
    logic [XLEN-1:0]     trap_pc;
    logic [63:0]         cycle_cnt;
    logic [63:0]         instr_cnt;
    logic                overflow;

    commit_stream_monitor #(.NCH(NCH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .in_wen(in_wen), .in_wdest(in_wdest),
        .in_wdata(in_wdata), .in_a0(in_a0), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata),
        .trap_valid(trap_valid), .trap_code(trap_code), .trap_pc(trap_pc),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_RUN, M_DRAIN, M_HALT} mmode_t;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wdest;
        logic [63:0] wdata;
        logic        trap;
        logic [7:0]  code;
    } ent_t;

    ent_t        mq[$];      // events accepted but not yet emitted
    ent_t        exp_q[$];   // events emitted by the model, awaiting the monitor
    mmode_t      m_mode      = M_RUN;
    logic [63:0] m_cycle     = '0;
    logic [63:0] m_instr     = '0;
    logic        m_ovf       = 1'b0;
    logic        m_trap      = 1'b0;
    logic [63:0] m_trap_pc   = '0;
    logic [7:0]  m_trap_code = '0;

    mmode_t m_old;
    int     m_sz;
    bit     m_rdy;
    bit     m_stop;
    ent_t   m_e;

    function automatic ent_t lane(input int k);
        ent_t e;
        e.pc    = in_pc[k*XLEN +: XLEN];
        e.inst  = in_inst[k*32 +: 32];
        e.wen   = in_wen[k];
        e.wdest = in_wdest[k*5 +: 5];
        e.wdata = in_wdata[k*XLEN +: XLEN];
        e.trap  = (e.inst[6:0] == 7'h6b);
        e.code  = in_a0[7:0];
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_mode = M_RUN; m_cycle = '0; m_instr = '0; m_ovf = 1'b0;
            m_trap = 1'b0; m_trap_pc = '0; m_trap_code = '0;
        end else begin
            m_old = m_mode;
            m_sz  = mq.size();
            m_rdy = (m_old == M_RUN) && (m_sz <= DEPTH - NCH);
            if (m_old != M_HALT) m_cycle++;
            if (m_old != M_HALT && m_sz > 0) begin
                m_e = mq.pop_front();
                exp_q.push_back(m_e);
                m_instr++;
                if (m_e.trap) begin
                    m_trap = 1'b1; m_trap_pc = m_e.pc; m_trap_code = m_e.code;
                    m_mode = M_HALT;
                end
            end
            if (m_old == M_RUN) begin
                if (m_rdy) begin
                    m_stop = 0;
                    for (int k = 0; k < NCH; k++) begin
                        if (in_valid[k] && !m_stop) begin
                            m_e = lane(k);
                            mq.push_back(m_e);
                            if (m_e.trap) begin
                                m_stop = 1;
                                m_mode = M_DRAIN;
                            end
                        end
                    end
                end else if (|in_valid) begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    ent_t mon_e;
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL out_unexpected: got pc 0x%0h, expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_pc",    out_pc,    mon_e.pc);
                chk("out_inst",  64'(out_inst),  64'(mon_e.inst));
                chk("out_wen",   64'(out_wen),   64'(mon_e.wen));
                chk("out_wdest", 64'(out_wdest), {59'd0, mon_e.wdest});
                chk("out_wdata", out_wdata, mon_e.wdata);
            end
        end else begin
            chk("out_missing", 64'(exp_q.size()), 64'd0);
        end
        chk("in_ready",   64'(in_ready),   64'((m_mode == M_RUN) && (mq.size() <= DEPTH - NCH)));
        chk("overflow",   64'(overflow),   64'(m_ovf));
        chk("trap_valid", 64'(trap_valid), 64'(m_trap));
        chk("trap_pc",    trap_pc,         m_trap_pc);
        chk("trap_code",  64'(trap_code),  64'(m_trap_code));
        chk("cycle_cnt",  cycle_cnt,       m_cycle);
        chk("instr_cnt",  instr_cnt,       m_instr);
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        in_valid = '0; in_pc = '0; in_inst = '0; in_wen = '0; in_wdest = '0; in_wdata = '0;
    endtask

    task automatic set_lane(input int k, input logic [63:0] pc, input logic [31:0] inst,
                            input logic wen, input logic [4:0] wd, input logic [63:0] wdata);
        in_valid[k]             = 1'b1;
        in_pc[k*XLEN +: XLEN]   = pc;
        in_inst[k*32 +: 32]     = inst;
        in_wen[k]               = wen;
        in_wdest[k*5 +: 5]      = wd;
        in_wdata[k*XLEN +: XLEN] = wdata;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r;
        r = $urandom;
        if (r[6:0] == 7'h6b) r[0] = ~r[0];
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    logic [63:0] pc_n     = 64'h8000_1000;
    bit          saw_drop = 0;
    logic [63:0] snap_cyc;
    logic [63:0] snap_ins;
    logic [4:0]  rwd;

    task automatic rnd_cycles(input int n, input int honour_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_in();
            in_a0 = rnd64();
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(0, 99) < 60) begin
                    rwd = 5'($urandom);
                    set_lane(k, pc_n, rnd_inst(), 1'($urandom), rwd, rnd64());
                    pc_n += 4;
                end
            end
            if (!in_ready && $urandom_range(0, 99) < honour_pct) in_valid = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); clear_in(); end
    endtask

    initial begin
        clear_in();
        in_a0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_cycle_cnt", cycle_cnt,      64'd0);
        rst_n = 1'b1;

        // single commit on lane 0
        @(negedge clk); clear_in();
        set_lane(0, 64'h8000_0000, 32'h0000_0013, 1'b1, 5'd5, 64'h1234);
        @(negedge clk); clear_in();
        @(posedge clk); #1;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_pc",    out_pc,         64'h8000_0000);
        chk("t1_out_wdest", 64'(out_wdest), 64'h05);
        chk("t1_instr_cnt", instr_cnt,      64'd1);
        @(posedge clk); #1;
        chk("t1_one_cycle", 64'(out_valid), 64'd0);

        // two lanes, then lane 1 alone: no hole in the output sequence
        @(negedge clk); clear_in();
        set_lane(0, 64'h8000_0100, 32'h0000_0013, 1'b0, 5'd1, 64'h1);
        set_lane(1, 64'h8000_0104, 32'h0000_0093, 1'b1, 5'd2, 64'h2);
        @(negedge clk); clear_in();
        set_lane(1, 64'h8000_0108, 32'h0000_0113, 1'b1, 5'd3, 64'h3);
        @(posedge clk); #1;
        chk("t2_pc0", out_pc, 64'h8000_0100);
        @(negedge clk); clear_in();
        @(posedge clk); #1;
        chk("t2_pc1", out_pc, 64'h8000_0104);
        @(posedge clk); #1;
        chk("t2_pc2", out_pc, 64'h8000_0108);
        idle(4);

        // both lanes every cycle while honouring in_ready
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); clear_in();
            if (in_ready) begin
                set_lane(0, pc_n, rnd_inst(), 1'b1, 5'd7, rnd64());
                set_lane(1, pc_n + 4, rnd_inst(), 1'b1, 5'd8, rnd64());
                pc_n += 8;
            end else begin
                saw_drop = 1;
            end
        end
        idle(12);
        chk("fill_ready_dropped", 64'(saw_drop), 64'd1);
        chk("fill_no_overflow",   64'(overflow), 64'd0);

        // push regardless of in_ready
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); clear_in();
            set_lane(0, pc_n, rnd_inst(), 1'b1, 5'd9, rnd64());
            set_lane(1, pc_n + 4, rnd_inst(), 1'b0, 5'd10, rnd64());
            pc_n += 8;
        end
        idle(12);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        rnd_cycles(300, 85);
        idle(12);

        // reset while draining three queued entries
        @(negedge clk); clear_in();
        set_lane(0, 64'h8000_2000, 32'h0000_0013, 1'b1, 5'd1, 64'h11);
        set_lane(1, 64'h8000_2004, 32'h0000_0013, 1'b1, 5'd2, 64'h22);
        @(negedge clk); clear_in();
        set_lane(0, 64'h8000_2008, 32'h0000_0013, 1'b1, 5'd3, 64'h33);
        set_lane(1, 64'h8000_200c, 32'h0000_006b, 1'b0, 5'd0, 64'h0);
        @(posedge clk); #1;
        chk("drain_ready_low", 64'(in_ready), 64'd0);
        #1; rst_n = 1'b0; clear_in();
        #1;
        chk("arst_out_valid",  64'(out_valid),  64'd0);
        chk("arst_out_pc",     out_pc,          64'd0);
        chk("arst_out_wdata",  out_wdata,       64'd0);
        chk("arst_trap_valid", 64'(trap_valid), 64'd0);
        chk("arst_cycle_cnt",  cycle_cnt,       64'd0);
        chk("arst_instr_cnt",  instr_cnt,       64'd0);
        chk("arst_overflow",   64'(overflow),   64'd0);
        chk("arst_in_ready",   64'(in_ready),   64'd1);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rnd_cycles(40, 100);
        idle(12);

        // trap on lane 0 with a younger lane 1 in the same cycle
        @(negedge clk); clear_in();
        in_a0 = 64'h0;
        set_lane(0, 64'h9000_0000, 32'h0000_006b, 1'b0, 5'd0, 64'h0);
        set_lane(1, 64'h9000_0004, 32'h0000_0013, 1'b1, 5'd4, 64'h44);
        @(negedge clk); clear_in();
        in_a0 = 64'hff;
        @(posedge clk); #1;
        chk("trap_out_valid", 64'(out_valid),  64'd1);
        chk("trap_valid_now", 64'(trap_valid), 64'd1);
        chk("trap_pc_now",    trap_pc,         64'h9000_0000);
        chk("trap_code_now",  64'(trap_code),  64'd0);
        snap_cyc = cycle_cnt;
        snap_ins = instr_cnt;
        rnd_cycles(10, 0);
        idle(2);
        chk("halt_cycle_frozen", cycle_cnt,      snap_cyc);
        chk("halt_instr_frozen", instr_cnt,      snap_ins);
        chk("halt_no_overflow",  64'(overflow),  64'd0);
        chk("halt_no_output",    64'(out_valid), 64'd0);
        chk("sb_drained",        64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
